bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 134 +++++++++++++
 tb/tb_bus_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: IDLE -> SETUP (route settles, no grant) -> BUSY (granted) -> RELEASE.
// bus_state updates one edge after an eligible request and grant follows one edge later; other requesters are held off until IDLE.
module bus_arbiter #(
    parameter int NO_MASTERS = 2,
    parameter int NO_SLAVES  = 3,
    parameter int S_ID_WIDTH = $clog2(NO_SLAVES + 1),
    parameter int M_ID_WIDTH = $clog2(NO_MASTERS),
    parameter int TIMEOUT    = 16
) (
    input  logic                             clk,
    input  logic                             rstN,
    input  logic                             req_M      [0:NO_MASTERS-1],
    input  logic [S_ID_WIDTH-1:0]            slave_id_M [0:NO_MASTERS-1],
    input  logic                             ready,
    output logic                             grant_M    [0:NO_MASTERS-1],
    output logic [M_ID_WIDTH+S_ID_WIDTH-1:0] bus_state,
    output logic                             timeout_err
);

    localparam int                    CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [S_ID_WIDTH-1:0] IDLE_ID = S_ID_WIDTH'(NO_SLAVES);
    localparam logic [M_ID_WIDTH-1:0] LAST_M  = M_ID_WIDTH'(NO_MASTERS - 1);

    typedef enum logic [1:0] {IDLE, SETUP, BUSY, RELEASE} state_t;

    state_t                          r_state, w_state_nxt;
    logic [M_ID_WIDTH-1:0]           r_owner, w_owner_nxt;
    logic [M_ID_WIDTH-1:0]           r_last, w_last_nxt;
    logic [M_ID_WIDTH-1:0]           w_winner;
    logic [CNT_W-1:0]                r_cnt, w_cnt_nxt;
    logic [NO_MASTERS-1:0]           r_grant, w_grant_nxt;
    logic [NO_MASTERS-1:0]           w_elig;
    logic [M_ID_WIDTH+S_ID_WIDTH-1:0] r_bus, w_bus_nxt;
    logic                            r_terr, w_terr_nxt;
    logic                            w_found;

    // A request aimed at the idle code (or beyond) never competes.
    always_comb begin
        for (int i = 0; i < NO_MASTERS; i++) begin
            w_elig[i] = req_M[i] && (slave_id_M[i] < IDLE_ID);
        end
    end

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < NO_MASTERS; i++) begin
            if (!w_found && w_elig[(int'(r_last) + 1 + i) % NO_MASTERS]) begin
                w_found  = 1'b1;
                w_winner = M_ID_WIDTH'((int'(r_last) + 1 + i) % NO_MASTERS);
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_last  <= LAST_M;
            r_cnt   <= '0;
            r_grant <= '0;
            r_bus   <= {{M_ID_WIDTH{1'b0}}, IDLE_ID};
            r_terr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_grant <= w_grant_nxt;
            r_bus   <= w_bus_nxt;
            r_terr  <= w_terr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_grant_nxt = '0;
        w_bus_nxt   = r_bus;
        w_terr_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_found) begin
                    w_state_nxt = SETUP;
                    w_owner_nxt = w_winner;
                    w_bus_nxt   = {w_winner, slave_id_M[w_winner]};
                end
            end
            SETUP: begin
                if (req_M[r_owner]) begin
                    w_state_nxt          = BUSY;
                    w_grant_nxt[r_owner] = 1'b1;
                end else begin
                    w_state_nxt = RELEASE;
                    w_bus_nxt   = {r_owner, IDLE_ID};
                end
            end
            BUSY: begin
                // A dropped request wins over a coinciding timeout: no error is flagged.
                if (!req_M[r_owner]) begin
                    w_state_nxt = RELEASE;
                    w_bus_nxt   = {r_owner, IDLE_ID};
                    w_cnt_nxt   = '0;
                end else if (!ready && (r_cnt == CNT_W'(TIMEOUT - 1))) begin
                    w_state_nxt = RELEASE;
                    w_bus_nxt   = {r_owner, IDLE_ID};
                    w_cnt_nxt   = '0;
                    w_terr_nxt  = 1'b1;
                end else begin
                    w_grant_nxt[r_owner] = 1'b1;
                    w_cnt_nxt            = ready ? '0 : r_cnt + 1'b1;
                end
            end
            RELEASE: begin
                w_state_nxt = IDLE;
                w_last_nxt  = r_owner;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NO_MASTERS; i++) begin
            grant_M[i] = r_grant[i];
        end
    end

    assign bus_state   = r_bus;
    assign timeout_err = r_terr;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter (2 masters, 3 slaves, timeout 16): directed scenarios plus a randomized run against a transaction-level model.
module tb_bus_arbiter;

    localparam int TIMEOUT = 16;

    logic       clk;
    logic       rstN;
    logic       req_M      [0:1];
    logic [1:0] slave_id_M [0:1];
    logic       ready;
    logic       grant_M    [0:1];
    logic [2:0] bus_state;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;

    bus_arbiter dut (
        .clk        (clk),
        .rstN       (rstN),
        .req_M      (req_M),
        .slave_id_M (slave_id_M),
        .ready      (ready),
        .grant_M    (grant_M),
        .bus_state  (bus_state),
        .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rstN          = 1'b0;
        req_M[0]      = 1'b0;
        req_M[1]      = 1'b0;
        slave_id_M[0] = 2'd0;
        slave_id_M[1] = 2'd0;
        ready         = 1'b1;
        tick();
        tick();
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        rstN = 1'b0;
        #2;
        total++;
        if ({grant_M[1], grant_M[0]} !== 2'b00 || bus_state !== 3'b011 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: grant=%b bus=%b terr=%b, want grant=00 bus=011 terr=0",
                     {grant_M[1], grant_M[0]}, bus_state, timeout_err);
        end
        rstN = 1'b1;
        tick();
        tick();
        total++;
        if ({grant_M[1], grant_M[0]} !== 2'b00 || bus_state !== 3'b011) begin
            bad++;
            $display("FAIL reset_idle: grant=%b bus=%b, want grant=00 bus=011",
                     {grant_M[1], grant_M[0]}, bus_state);
        end
    endtask

    task automatic test_single();
        apply_reset();
        req_M[0]      = 1'b1;
        slave_id_M[0] = 2'd2;
        tick();
        total++;
        if ({grant_M[1], grant_M[0]} !== 2'b00 || bus_state !== 3'b010) begin
            bad++;
            $display("FAIL single_setup: grant=%b bus=%b, want grant=00 bus=010",
                     {grant_M[1], grant_M[0]}, bus_state);
        end
        tick();
        total++;
        if ({grant_M[1], grant_M[0]} !== 2'b01) begin
            bad++;
            $display("FAIL single_grant: grant=%b, want 01", {grant_M[1], grant_M[0]});
        end
        slave_id_M[0] = 2'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({grant_M[1], grant_M[0]} !== 2'b01 || bus_state !== 3'b010) begin
                bad++;
                $display("FAIL single_hold: cycle %0d grant=%b bus=%b, want grant=01 bus=010",
                         i, {grant_M[1], grant_M[0]}, bus_state);
            end
        end
        req_M[0] = 1'b0;
        tick();
        total++;
        if ({grant_M[1], grant_M[0]} !== 2'b00 || bus_state !== 3'b011) begin
            bad++;
            $display("FAIL single_release: grant=%b bus=%b, want grant=00 bus=011",
                     {grant_M[1], grant_M[0]}, bus_state);
        end
    endtask

    task automatic test_contention();
        apply_reset();
        req_M[0] = 1'b1; slave_id_M[0] = 2'd0;
        req_M[1] = 1'b1; slave_id_M[1] = 2'd1;
        tick();
        total++;
        if (bus_state !== 3'b000 || {grant_M[1], grant_M[0]} !== 2'b00) begin
            bad++;
            $display("FAIL cont_first_setup: bus=%b grant=%b, want bus=000 grant=00",
                     bus_state, {grant_M[1], grant_M[0]});
        end
        tick();
        tick();
        total++;
        if ({grant_M[1], grant_M[0]} !== 2'b01) begin
            bad++;
            $display("FAIL cont_m0_grant: grant=%b, want 01", {grant_M[1], grant_M[0]});
        end
        req_M[0] = 1'b0;
        tick();
        tick();
        total++;
        if ({grant_M[1], grant_M[0]} !== 2'b00 || bus_state !== 3'b011) begin
            bad++;
            $display("FAIL cont_gap: grant=%b bus=%b, want grant=00 bus=011",
                     {grant_M[1], grant_M[0]}, bus_state);
        end
        tick();
        total++;
        if (bus_state !== 3'b101 || {grant_M[1], grant_M[0]} !== 2'b00) begin
            bad++;
            $display("FAIL cont_m1_setup: bus=%b grant=%b, want bus=101 grant=00",
                     bus_state, {grant_M[1], grant_M[0]});
        end
        req_M[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({grant_M[1], grant_M[0]} !== 2'b10) begin
                bad++;
                $display("FAIL cont_m1_hold: cycle %0d grant=%b, want 10", i, {grant_M[1], grant_M[0]});
            end
        end
        req_M[1] = 1'b0;
        tick();
        total++;
        if ({grant_M[1], grant_M[0]} !== 2'b00 || bus_state !== 3'b111) begin
            bad++;
            $display("FAIL cont_m1_release: grant=%b bus=%b, want grant=00 bus=111",
                     {grant_M[1], grant_M[0]}, bus_state);
        end
        tick();
        tick();
        total++;
        if (bus_state !== 3'b000) begin
            bad++;
            $display("FAIL cont_m0_again_setup: bus=%b, want 000", bus_state);
        end
        tick();
        total++;
        if ({grant_M[1], grant_M[0]} !== 2'b01) begin
            bad++;
            $display("FAIL cont_m0_again_grant: grant=%b, want 01", {grant_M[1], grant_M[0]});
        end
    endtask

    task automatic test_invalid_id();
        apply_reset();
        req_M[1]      = 1'b1;
        slave_id_M[1] = 2'd3;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if ({grant_M[1], grant_M[0]} !== 2'b00 || bus_state !== 3'b011 || timeout_err !== 1'b0) begin
                bad++;
                $display("FAIL invalid_id: cycle %0d grant=%b bus=%b terr=%b, want 00 011 0",
                         i, {grant_M[1], grant_M[0]}, bus_state, timeout_err);
            end
        end
    endtask

    task automatic test_timeout();
        int held;
        apply_reset();
        req_M[0]      = 1'b1;
        slave_id_M[0] = 2'd1;
        ready         = 1'b0;
        tick();
        tick();
        held = 0;
        // A single ready cycle after 10 low ones restarts the count.
        for (int i = 0; i < 10; i++) begin
            tick();
            if (grant_M[0] === 1'b1 && timeout_err === 1'b0) held++;
        end
        ready = 1'b1;
        tick();
        if (grant_M[0] === 1'b1) held++;
        ready = 1'b0;
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            tick();
            if (grant_M[0] === 1'b1 && timeout_err === 1'b0) held++;
        end
        total++;
        if (held !== 26) begin
            bad++;
            $display("FAIL timeout_hold: granted cycles=%0d, want 26", held);
        end
        tick();
        total++;
        if ({grant_M[1], grant_M[0]} !== 2'b00 || timeout_err !== 1'b1 || bus_state !== 3'b011) begin
            bad++;
            $display("FAIL timeout_fire: grant=%b terr=%b bus=%b, want 00 1 011",
                     {grant_M[1], grant_M[0]}, timeout_err, bus_state);
        end
        req_M[0] = 1'b0;
        tick();
        total++;
        if (timeout_err !== 1'b0 || {grant_M[1], grant_M[0]} !== 2'b00) begin
            bad++;
            $display("FAIL timeout_pulse: terr=%b grant=%b, want 0 00", timeout_err, {grant_M[1], grant_M[0]});
        end
        ready = 1'b1;
    endtask

    task automatic test_setup_abort();
        apply_reset();
        req_M[1]      = 1'b1;
        slave_id_M[1] = 2'd2;
        tick();
        total++;
        if (bus_state !== 3'b110) begin
            bad++;
            $display("FAIL abort_setup: bus=%b, want 110", bus_state);
        end
        req_M[1] = 1'b0;
        tick();
        total++;
        if (bus_state !== 3'b111 || {grant_M[1], grant_M[0]} !== 2'b00) begin
            bad++;
            $display("FAIL abort_release: bus=%b grant=%b, want 111 00", bus_state, {grant_M[1], grant_M[0]});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if ({grant_M[1], grant_M[0]} !== 2'b00) begin
                bad++;
                $display("FAIL abort_no_grant: cycle %0d grant=%b, want 00", i, {grant_M[1], grant_M[0]});
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        req_M[0]      = 1'b1;
        slave_id_M[0] = 2'd2;
        tick();
        tick();
        #3;
        rstN = 1'b0;
        #1;
        total++;
        if ({grant_M[1], grant_M[0]} !== 2'b00 || bus_state !== 3'b011 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: grant=%b bus=%b terr=%b, want 00 011 0",
                     {grant_M[1], grant_M[0]}, bus_state, timeout_err);
        end
        #1;
        rstN = 1'b1;
        tick();
        total++;
        if (bus_state !== 3'b010 || {grant_M[1], grant_M[0]} !== 2'b00) begin
            bad++;
            $display("FAIL async_restart_setup: bus=%b grant=%b, want 010 00", bus_state, {grant_M[1], grant_M[0]});
        end
        tick();
        total++;
        if ({grant_M[1], grant_M[0]} !== 2'b01) begin
            bad++;
            $display("FAIL async_restart_grant: grant=%b, want 01", {grant_M[1], grant_M[0]});
        end
    endtask

    // Model tracks one transaction record: who won, when, when it ended; the bus reopens two edges after the end.
    task automatic test_random();
        int         m_owner, m_won, m_end, m_last, m_low, c;
        bit         done;
        logic [1:0] e_grant;
        logic [2:0] e_bus;
        logic       e_terr;
        apply_reset();
        m_owner = -1; m_won = 0; m_end = -2; m_last = 1; m_low = 0;
        e_grant = 2'b00; e_bus = 3'b011; e_terr = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 99) < 8)  req_M[i] = ~req_M[i];
                if ($urandom_range(0, 99) < 10) slave_id_M[i] = 2'($urandom_range(0, 3));
            end
            ready = (n < 700) ? ($urandom_range(0, 99) < 80) : ($urandom_range(0, 99) < 4);

            e_terr = 1'b0;
            done   = 1'b0;
            if (m_owner < 0) begin
                if (n >= m_end + 2) begin
                    for (int k = 0; k < 2; k++) begin
                        c = (m_last + 1 + k) % 2;
                        if (m_owner < 0 && req_M[c] && slave_id_M[c] < 2'd3) begin
                            m_owner = c;
                            m_won   = n;
                            m_low   = 0;
                            e_bus   = {1'(c), slave_id_M[c]};
                        end
                    end
                end
            end else if (n == m_won + 1) begin
                if (req_M[m_owner]) e_grant = 2'b01 << m_owner;
                else                done    = 1'b1;
            end else if (!req_M[m_owner]) begin
                done = 1'b1;
            end else if (!ready) begin
                m_low++;
                if (m_low == TIMEOUT) begin
                    done   = 1'b1;
                    e_terr = 1'b1;
                end
            end else begin
                m_low = 0;
            end
            if (done) begin
                e_grant = 2'b00;
                e_bus   = {1'(m_owner), 2'd3};
                m_end   = n;
                m_last  = m_owner;
                m_owner = -1;
            end

            tick();
            total++;
            if ({grant_M[1], grant_M[0]} !== e_grant) begin
                bad++;
                $display("FAIL rnd_grant: cycle %0d grant=%b, want %b", n, {grant_M[1], grant_M[0]}, e_grant);
            end
            total++;
            if (bus_state !== e_bus) begin
                bad++;
                $display("FAIL rnd_bus: cycle %0d bus=%b, want %b", n, bus_state, e_bus);
            end
            total++;
            if (timeout_err !== e_terr) begin
                bad++;
                $display("FAIL rnd_terr: cycle %0d terr=%b, want %b", n, timeout_err, e_terr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_invalid_id();
        test_timeout();
        test_setup_abort();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
